// File: rtl/pipe_result_collector.sv
// rtl/pipe_result_collector.sv - first-word fall-through result FIFO with optional running statistics (PIPE_STATS_EN)
module pipe_result_collector #(
    parameter int N     = 10,
    parameter int DEPTH = 4,
    parameter int ACC_W = N + 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             f,
    input  logic                     f_valid,
    output logic [N-1:0]             m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
`ifdef PIPE_STATS_EN
    output logic [ACC_W-1:0]         sum,
    output logic [N-1:0]             max_f,
    output logic [N-1:0]             min_f,
    output logic [15:0]              n_samp,
`endif
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [LW-1:0] level_q;
    logic          overflow_q;
    logic          rd;
    logic          wr;

    // Outputs decode only registered state; the head is forced to zero when empty
    assign m_valid  = (level_q != '0);
    assign full     = (level_q == LW'(DEPTH));
    assign level    = level_q;
    assign overflow = overflow_q;
    assign m_data   = m_valid ? mem[rptr] : '0;

    // A write is still accepted at full when the head leaves in the same edge
    assign rd = m_valid && m_ready;
    assign wr = f_valid && (!full || rd);

    // Storage array; not reset, the head is masked while empty
    always_ff @(posedge clk) begin
        if (!rst && wr) begin
            mem[wptr] <= f;
        end
    end

    // Pointers, occupancy and the sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr) begin
                wptr <= wptr + PW'(1);
            end
            if (rd) begin
                rptr <= rptr + PW'(1);
            end
            case ({wr, rd})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (f_valid && full && !rd) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef PIPE_STATS_EN
    logic [ACC_W:0] sum_ext;
    logic [ACC_W-1:0] sum_q;
    logic [N-1:0]     max_q;
    logic [N-1:0]     min_q;
    logic [15:0]      cnt_q;

    assign sum_ext = {1'b0, sum_q} + {{(ACC_W + 1 - N){1'b0}}, f};
    assign sum     = sum_q;
    assign max_f   = max_q;
    assign min_f   = min_q;
    assign n_samp  = cnt_q;

    // Running statistics over accepted writes only, saturating sum and count
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            cnt_q <= '0;
            max_q <= '0;
            min_q <= '1;
        end else if (wr) begin
            sum_q <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            if (cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (f > max_q) begin
                max_q <= f;
            end
            if (f < min_q) begin
                min_q <= f;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_result_collector.sv
// tb/tb_pipe_result_collector.sv - scoreboard bench for pipe_result_collector
module tb_pipe_result_collector;

    localparam int N     = 10;
    localparam int DEPTH = 4;
    localparam int ACC_W = N + 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  f;
    logic          f_valid;
    logic          m_ready;
    logic [N-1:0]  m_data;
    logic          m_valid;
    logic [LW-1:0] level;
    logic          full;
    logic          overflow;

    always #5 clk = ~clk;

`ifdef PIPE_STATS_EN
    logic [ACC_W-1:0] sum;
    logic [N-1:0]     max_f;
    logic [N-1:0]     min_f;
    logic [15:0]      n_samp;

    logic [N-1:0]  f2;
    logic          f_valid2;
    logic [N-1:0]  m_data2;
    logic          m_valid2;
    logic [LW-1:0] level2;
    logic          full2;
    logic          overflow2;
    logic [10:0]   sum2;
    logic [N-1:0]  max_f2;
    logic [N-1:0]  min_f2;
    logic [15:0]   n_samp2;

    pipe_result_collector #(.N(N), .DEPTH(DEPTH), .ACC_W(11)) u_sat (
        .clk(clk), .rst(rst), .f(f2), .f_valid(f_valid2),
        .m_data(m_data2), .m_valid(m_valid2), .m_ready(1'b0),
        .level(level2), .full(full2),
        .sum(sum2), .max_f(max_f2), .min_f(min_f2), .n_samp(n_samp2),
        .overflow(overflow2)
    );
`endif

    pipe_result_collector #(.N(N), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .f(f), .f_valid(f_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .full(full),
`ifdef PIPE_STATS_EN
        .sum(sum), .max_f(max_f), .min_f(min_f), .n_samp(n_samp),
`endif
        .overflow(overflow)
    );

    int           checks   = 0;
    int           failures = 0;
    logic [N-1:0] exp_q[$];
    bit           m_ovf;
    longint       m_sum;
    int           m_n;
    int           m_max;
    int           m_min;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 1'b0;
        m_sum = 0;
        m_n   = 0;
        m_max = 0;
        m_min = (1 << N) - 1;
    endtask

    task automatic check_state();
        check("level", 32'(level), 32'(exp_q.size()));
        check("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
        check("full", 32'(full), 32'(exp_q.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (exp_q.size() != 0) check("head", 32'(m_data), 32'(exp_q[0]));
        else                   check("head_empty", 32'(m_data), 32'd0);
`ifdef PIPE_STATS_EN
        check("sum", 32'(sum), 32'(m_sum));
        check("n_samp", 32'(n_samp), 32'(m_n));
        check("max_f", 32'(max_f), 32'(m_max));
        check("min_f", 32'(min_f), 32'(m_min));
`endif
    endtask

    // Entered just after a falling edge; drives one cycle and checks the result
    task automatic cycle(input bit fv, input logic [N-1:0] d, input bit mr);
        bit rd;
        bit wr;
        f_valid = fv;
        f       = d;
        m_ready = mr;
        rd = (exp_q.size() != 0) && mr;
        wr = fv && ((exp_q.size() < DEPTH) || rd);
        if (rd) begin
            check("rd_data", 32'(m_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        if (wr) begin
            exp_q.push_back(d);
            m_sum = m_sum + longint'(d);
            if (m_sum > (longint'(1) << ACC_W) - 1) m_sum = (longint'(1) << ACC_W) - 1;
            if (m_n < 65535) m_n++;
            if (int'(d) > m_max) m_max = int'(d);
            if (int'(d) < m_min) m_min = int'(d);
        end else if (fv) begin
            m_ovf = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic do_reset(input bit fv, input logic [N-1:0] d);
        rst     = 1'b1;
        f_valid = fv;
        f       = d;
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        f_valid = 1'b0;
        model_reset();
        check_state();
    endtask

    initial begin
        rst      = 1'b1;
        f        = '0;
        f_valid  = 1'b0;
        m_ready  = 1'b0;
`ifdef PIPE_STATS_EN
        f2       = '0;
        f_valid2 = 1'b0;
`endif
        @(negedge clk);
        do_reset(1'b0, '0);

`ifdef PIPE_STATS_EN
        f2 = 10'd1023;
        f_valid2 = 1'b1;
        @(posedge clk); @(negedge clk);
        check("sat_sum1", 32'(sum2), 32'd1023);
        @(posedge clk); @(negedge clk);
        check("sat_sum2", 32'(sum2), 32'd2046);
        @(posedge clk); @(negedge clk);
        f_valid2 = 1'b0;
        check("sat_sum3", 32'(sum2), 32'd2047);
        check("sat_n", 32'(n_samp2), 32'd3);
`endif

        // single result, first-word fall-through
        cycle(1'b1, 10'd124, 1'b0);
        check("req030_data", 32'(m_data), 32'd124);
        check("req030_level", 32'(level), 32'd1);
        cycle(1'b0, '0, 1'b1);

        // overfill then drain
        for (int i = 1; i <= 5; i++) cycle(1'b1, N'(i), 1'b0);
        check("req031_full", 32'(full), 32'd1);
        check("req031_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        check("req031_ovf_sticky", 32'(overflow), 32'd1);

        // simultaneous read and write at full
        do_reset(1'b0, '0);
        for (int i = 20; i < 24; i++) cycle(1'b1, N'(i), 1'b0);
        cycle(1'b1, 10'd24, 1'b1);
        check("req032_level", 32'(level), 32'd4);
        check("req032_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

        // streaming across pointer wrap
        for (int i = 10; i < 20; i++) begin
            cycle(1'b1, N'(i), 1'b1);
            check("req033_lvl_le1", 32'(level <= 1), 32'd1);
        end
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("underflow_level", 32'(level), 32'd0);

        // statistics and mid-stream reset with an in-flight sample
        do_reset(1'b0, '0);
        cycle(1'b1, 10'd100, 1'b0);
        cycle(1'b1, 10'd7, 1'b0);
        cycle(1'b1, 10'd300, 1'b0);
`ifdef PIPE_STATS_EN
        check("req034_sum", 32'(sum), 32'd407);
        check("req034_n", 32'(n_samp), 32'd3);
        check("req034_max", 32'(max_f), 32'd300);
        check("req034_min", 32'(min_f), 32'd7);
`endif
        do_reset(1'b1, 10'd55);
        check("rst_level", 32'(level), 32'd0);
        check("rst_mdata", 32'(m_data), 32'd0);

        // randomized traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), N'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_result_collector.md
PIPE_RESULT_COLLECTOR -- requirements
Module: pipe_result_collector

Interface
REQ-001 SHALL have parameter N, default 10, the result width, equal to the pipe output width.
REQ-002 SHALL have parameter DEPTH, default 4, the FIFO entries; it SHALL be a power of two, 2 to 16.
REQ-003 SHALL have parameter ACC_W, default N+8, the accumulator width.
REQ-004 SHALL have port clk, input, width 1: the single clock, rising-edge active.
REQ-005 SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-006 SHALL have port f, input, width N: the result from the upstream pipe.
REQ-007 SHALL have port f_valid, input, width 1: f holds a valid result this cycle.
REQ-008 SHALL have port m_data, output, width N: the FIFO head.
REQ-009 SHALL have port m_valid, output, width 1: m_data is valid.
REQ-010 SHALL have port m_ready, input, width 1: the consumer accepts m_data.
REQ-011 SHALL have port level, output, width clog2(DEPTH)+1: FIFO occupancy.
REQ-012 SHALL have port full, output, width 1: level equals DEPTH.
REQ-013 SHALL have port overflow, output, width 1: sticky flag, a result was dropped.
REQ-014 SHALL have ports sum (ACC_W), max_f (N), min_f (N) and n_samp (16), all outputs, present only with PIPE_STATS_EN.

Function
REQ-015 A write SHALL occur on a rising edge where f_valid=1 and (full=0 or (m_valid=1 and m_ready=1)).
REQ-016 A read SHALL occur on a rising edge where m_valid=1 and m_ready=1.
REQ-017 f_valid=1 with full=1 and no read SHALL drop f, set overflow, and leave FIFO contents unchanged.
REQ-018 First-word fall-through: m_data SHALL always equal the oldest stored entry and m_valid SHALL equal (level!=0).
REQ-019 Latency: a result written at edge k SHALL be visible on m_data/m_valid after edge k when the FIFO was empty.
REQ-020 A simultaneous read and write SHALL leave level unchanged, including at level=DEPTH and level=1.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO across wrap.
REQ-022 m_ready with m_valid=0 SHALL have no effect; level SHALL never underflow.
REQ-023 overflow SHALL remain 1 until rst.
REQ-024 All outputs SHALL be registered or decoded only from registered state; no combinational path from f/f_valid/m_ready to any output.

Reset
REQ-025 On rst=1 at a rising edge: level=0, m_valid=0, full=0, overflow=0, pointers=0, m_data=0.
REQ-026 With PIPE_STATS_EN, reset SHALL set sum=0, n_samp=0, max_f=0, and min_f=all ones.
REQ-027 rst SHALL take priority over a simultaneous write or read; the in-flight sample SHALL be discarded.

Configuration
REQ-028 Macro PIPE_STATS_EN defined: on every accepted write (not dropped ones), the block SHALL update its statistics in the same edge: sum+=f saturating at 2^ACC_W-1, n_samp+=1 saturating at 16'hFFFF, max_f=max(max_f,f), min_f=min(min_f,f).
REQ-029 Macro PIPE_STATS_EN undefined: sum/max_f/min_f/n_samp ports and logic SHALL be absent; FIFO behaviour SHALL be identical.

Verification
REQ-030 Reset, then f=124 with f_valid=1 for one cycle and m_ready=0: next cycle m_valid=1, m_data=124, level=1.
REQ-031 With m_ready=0, write 5 results 1,2,3,4,5 (DEPTH=4): level=4, full=1, overflow=1, and reads return 1,2,3,4 in order.
REQ-032 At full with f_valid=1 and m_ready=1: level stays 4, overflow stays 0, and the new value appears after the three older ones.
REQ-033 Stream 10 results 10..19 with m_ready=1 throughout: pointer wrap occurs, outputs are 10..19 in order, and level never exceeds 1.
REQ-034 PIPE_STATS_EN, write 100,7,300: sum=407, n_samp=3, max_f=300, min_f=7; assert rst mid-stream and confirm all REQ-025/026 values.
REQ-035 PIPE_STATS_EN, ACC_W=11, write 1023 three times: sum saturates at 2047.
